// File: rtl/weight_load_ctrl.sv
// Weight-load controller: fetches weight rows from the buffer into the weight FIFO
// and feeds them tile-by-tile to the systolic array.
package tpu_package;
    localparam int unsigned MUL_SIZE = 32;
    localparam int unsigned W_WIDTH  = 7;
endpackage

module weight_load_ctrl #(
    parameter int unsigned MUL_SIZE = tpu_package::MUL_SIZE,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [7:0]        num_tiles_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              fifo_write_en_o,
    output logic              fifo_sending_o,
    input  logic              fifo_request_i,
    input  logic              fifo_valid_i,
    output logic              fifo_read_en_o,
    input  logic              array_ready_i,
    output logic              w_load_o,
    output logic              tile_last_o
);

    localparam int unsigned ROWS_W = 13;
    localparam int unsigned TILE_W = 8;
    localparam int unsigned ROW_W  = (MUL_SIZE > 1) ? $clog2(MUL_SIZE) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_TILE = 2'd1,
        S_LOAD_TILE = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_active;
    logic                r_busy;
    logic                r_done;
    logic                r_sending;
    logic                r_w_load;
    logic                r_tile_last;
    logic [ADDR_W-1:0]   r_base;
    logic [ROWS_W-1:0]   r_total;
    logic [ROWS_W-1:0]   r_fetched;
    logic [TILE_W-1:0]   r_num_tiles;
    logic [TILE_W-1:0]   r_tiles;
    logic [ROW_W-1:0]    r_row;

    logic w_rd_en;
    logic w_fifo_rd;
    logic w_row_last;
    logic w_job_last;

    // Fetch and consume handshakes are same-cycle on the FIFO/array inputs
    assign w_rd_en    = r_active & fifo_request_i & (r_fetched < r_total) & ~rst_i;
    assign w_fifo_rd  = (r_state == S_LOAD_TILE) & fifo_valid_i & ~rst_i;
    assign w_row_last = (r_row == ROW_W'(MUL_SIZE - 1));
    assign w_job_last = ((r_tiles + TILE_W'(1)) == r_num_tiles);

    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign mem_rd_en_o     = w_rd_en;
    assign mem_addr_o      = r_base + ADDR_W'(r_fetched);
    assign fifo_write_en_o = r_active;
    assign fifo_sending_o  = r_sending;
    assign fifo_read_en_o  = w_fifo_rd;
    assign w_load_o        = r_w_load;
    assign tile_last_o     = r_tile_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_active    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sending   <= 1'b0;
            r_w_load    <= 1'b0;
            r_tile_last <= 1'b0;
            r_base      <= '0;
            r_total     <= '0;
            r_fetched   <= '0;
            r_num_tiles <= '0;
            r_tiles     <= '0;
            r_row       <= '0;
        end else begin
            r_sending   <= w_rd_en;
            r_w_load    <= w_fifo_rd;
            r_tile_last <= w_fifo_rd & w_row_last;
            r_done      <= 1'b0;
            if (w_rd_en) begin
                r_fetched <= r_fetched + ROWS_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_base      <= base_addr_i;
                        r_total     <= ROWS_W'(num_tiles_i) * ROWS_W'(MUL_SIZE);
                        r_num_tiles <= num_tiles_i;
                        r_fetched   <= '0;
                        r_tiles     <= '0;
                        r_row       <= '0;
                        r_busy      <= 1'b1;
                        if (num_tiles_i == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= S_WAIT_TILE;
                            r_active <= 1'b1;
                        end
                    end
                end
                S_WAIT_TILE: begin
                    if (array_ready_i && fifo_valid_i) begin
                        r_state <= S_LOAD_TILE;
                        r_row   <= '0;
                    end
                end
                S_LOAD_TILE: begin
                    // A missing FIFO row simply stalls here; the array is not re-checked
                    if (w_fifo_rd) begin
                        if (w_row_last) begin
                            r_row   <= '0;
                            r_tiles <= r_tiles + TILE_W'(1);
                            if (w_job_last) begin
                                r_state  <= S_DONE;
                                r_done   <= 1'b1;
                                r_active <= 1'b0;
                            end else begin
                                r_state <= S_WAIT_TILE;
                            end
                        end else begin
                            r_row <= r_row + ROW_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Directed bench for weight_load_ctrl with a small occupancy model of the weight FIFO.
module tb_weight_load_ctrl;

    localparam int unsigned MUL   = 32;
    localparam int unsigned AW    = 16;
    localparam int          DEPTH = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [7:0]    num_tiles_i;
    logic          busy_o;
    logic          done_o;
    logic          mem_rd_en_o;
    logic [AW-1:0] mem_addr_o;
    logic          fifo_write_en_o;
    logic          fifo_sending_o;
    logic          fifo_request_i;
    logic          fifo_valid_i;
    logic          fifo_read_en_o;
    logic          array_ready_i;
    logic          w_load_o;
    logic          tile_last_o;

    weight_load_ctrl #(.MUL_SIZE(MUL), .ADDR_W(AW)) u_dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .base_addr_i     (base_addr_i),
        .num_tiles_i     (num_tiles_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .mem_rd_en_o     (mem_rd_en_o),
        .mem_addr_o      (mem_addr_o),
        .fifo_write_en_o (fifo_write_en_o),
        .fifo_sending_o  (fifo_sending_o),
        .fifo_request_i  (fifo_request_i),
        .fifo_valid_i    (fifo_valid_i),
        .fifo_read_en_o  (fifo_read_en_o),
        .array_ready_i   (array_ready_i),
        .w_load_o        (w_load_o),
        .tile_last_o     (tile_last_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    int            n_rd, n_frd, n_ld, n_tl, n_done, occ, stall, gap, total;
    logic          prev_rd, prev_frd;
    logic [AW-1:0] exp_base;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_job(input logic [AW-1:0] base, input int tiles);
        n_rd = 0; n_frd = 0; n_ld = 0; n_tl = 0; n_done = 0;
        occ = 0; stall = 0; gap = 0;
        prev_rd = 1'b0; prev_frd = 1'b0;
        exp_base = base;
        total = tiles * int'(MUL);
    endtask

    // mode 1: request toggles and valid stalls mid-tile; mode 2: array gaps between tiles
    task automatic drive_env(input int mode, input int k);
        fifo_valid_i   = (occ > 0) && (stall == 0);
        fifo_request_i = (occ < DEPTH) && ((mode != 1) || ((k % 2) == 1));
        array_ready_i  = (gap == 0);
    endtask

    task automatic sample(input int mode);
        logic [AW-1:0] ea;
        if (mem_rd_en_o) begin
            ea = exp_base + AW'(n_rd);
            check("rd_addr", 32'(mem_addr_o), 32'(ea));
            n_rd++;
            check("rd_bound", 32'(n_rd <= total), 1);
        end
        check("rd_gate", 32'(mem_rd_en_o & ~fifo_request_i), 0);
        check("sending", 32'(fifo_sending_o), 32'(prev_rd));
        check("w_load", 32'(w_load_o), 32'(prev_frd));
        check("frd_gate", 32'(fifo_read_en_o & ~fifo_valid_i), 0);
        if (gap > 0) check("wait_hold", 32'(fifo_read_en_o), 0);
        if (w_load_o) n_ld++;
        if (tile_last_o) begin
            check("tl_qual", 32'(w_load_o), 1);
            n_tl++;
            check("tl_row", 32'(n_ld % int'(MUL)), 0);
        end
        if (done_o) n_done++;
        if (fifo_read_en_o) n_frd++;
        occ = occ + int'(fifo_sending_o) - int'(fifo_read_en_o);
        if (stall > 0) stall--;
        if (gap > 0) gap--;
        if (fifo_read_en_o && mode == 1 && n_frd == 10) stall = 3;
        if (fifo_read_en_o && mode == 2 && (n_frd % int'(MUL)) == 0) gap = 5;
        prev_rd  = mem_rd_en_o;
        prev_frd = fifo_read_en_o;
    endtask

    task automatic run_job(input logic [AW-1:0] base, input int tiles, input int mode);
        logic seen;
        int   done_k;
        clear_job(base, tiles);
        seen = 1'b0;
        done_k = 0;
        @(posedge clk_i); #1;
        base_addr_i = base;
        num_tiles_i = 8'(tiles);
        start_i     = 1'b1;
        drive_env(mode, 0);
        @(negedge clk_i);
        check("idle_busy", 32'(busy_o), 0);
        sample(mode);
        for (int k = 1; k < 3000 && !seen; k++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            drive_env(mode, k);
            @(negedge clk_i);
            check("busy", 32'(busy_o), 1);
            if (done_o) begin
                seen = 1'b1;
                done_k = k;
                if (tiles > 0) begin
                    check("done_wl", 32'(w_load_o), 1);
                    check("done_tl", 32'(tile_last_o), 1);
                end
            end
            sample(mode);
        end
        check("done_seen", 32'(seen), 1);
        if (tiles == 0) check("done_lat", 32'(done_k), 1);
        @(posedge clk_i); #1;
        drive_env(mode, 0);
        @(negedge clk_i);
        check("post_busy", 32'(busy_o), 0);
        check("post_done", 32'(done_o), 0);
        check("post_rd", 32'(mem_rd_en_o), 0);
        check("post_wren", 32'(fifo_write_en_o), 0);
        sample(mode);
        check("n_rd", 32'(n_rd), 32'(total));
        check("n_frd", 32'(n_frd), 32'(total));
        check("n_ld", 32'(n_ld), 32'(total));
        check("n_tl", 32'(n_tl), 32'(tiles));
        check("n_done", 32'(n_done), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_done"}, 32'(done_o), 0);
        check({tag, "_rd"}, 32'(mem_rd_en_o), 0);
        check({tag, "_addr"}, 32'(mem_addr_o), 0);
        check({tag, "_wren"}, 32'(fifo_write_en_o), 0);
        check({tag, "_send"}, 32'(fifo_sending_o), 0);
        check({tag, "_frd"}, 32'(fifo_read_en_o), 0);
        check({tag, "_wload"}, 32'(w_load_o), 0);
        check({tag, "_tlast"}, 32'(tile_last_o), 0);
    endtask

    // Abort a 3-tile job in tile 2 after an ignored start while busy
    task automatic reset_abort();
        logic hit;
        clear_job(16'h0100, 3);
        hit = 1'b0;
        @(posedge clk_i); #1;
        base_addr_i = 16'h0100;
        num_tiles_i = 8'd3;
        start_i     = 1'b1;
        drive_env(0, 0);
        @(negedge clk_i);
        sample(0);
        for (int k = 1; k < 500 && !hit; k++) begin
            @(posedge clk_i); #1;
            start_i = (k == 20);
            if (k == 20) begin
                base_addr_i = 16'h1234;
                num_tiles_i = 8'd0;
            end
            drive_env(0, k);
            @(negedge clk_i);
            check("ab_busy", 32'(busy_o), 1);
            sample(0);
            if (n_frd >= 40) hit = 1'b1;
        end
        check("ab_reached", 32'(hit), 1);
        check("ab_no_done", 32'(n_done), 0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        start_i = 1'b1;
        num_tiles_i = 8'd1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        start_i = 1'b0;
        fifo_valid_i = 1'b1;
        fifo_request_i = 1'b1;
        array_ready_i = 1'b1;
        @(negedge clk_i);
        check_all_zero("ab");
        for (int k = 0; k < 40; k++) begin
            @(posedge clk_i); #1;
            @(negedge clk_i);
            check("ab_idle_busy", 32'(busy_o), 0);
            check("ab_idle_done", 32'(done_o), 0);
            check("ab_idle_rd", 32'(mem_rd_en_o), 0);
            check("ab_idle_send", 32'(fifo_sending_o), 0);
            check("ab_idle_wload", 32'(w_load_o), 0);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        base_addr_i = '0;
        num_tiles_i = '0;
        fifo_request_i = 1'b0;
        fifo_valid_i = 1'b0;
        array_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        start_i = 1'b1;
        num_tiles_i = 8'd2;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
        check_all_zero("rst");
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        run_job(16'h0010, 1, 0);
        run_job(16'h0000, 0, 0);
        run_job(16'hFFF0, 1, 0);
        run_job(16'h0200, 2, 1);
        run_job(16'h0400, 3, 2);
        reset_abort();
        run_job(16'h0020, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
